pipe_stage_buf: RTL and testbench

Parametrised pipeline stage register with valid/ready handshake, a two-entry skid buffer, and synchronous flush. It generalises the fixed EX→MEM latch to any control/data width, adds back-pressure without combinational ready paths, and kills in-flight control bits on flush. It is instantiated between every pair of pipeline stages (EX/MEM first, then ID/EX and MEM/WB).

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_sat_counter.sv | 26 ++
 rtl/pipe_stage_buf.sv | 166 ++++++++++++++++
 tb/tb_pipe_stage_buf.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage buffers: occupancy states, control-bit
// positions and default bundle widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } pipe_state_e;

    localparam int CTRL_MEMWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_REGWRITE = 2;

    localparam int PIPE_CTRL_W_DEF = 3;
    localparam int PIPE_DATA_W_DEF = 16;
    localparam int STALL_CNT_W     = 16;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count enabled cycles, stopping at the maximum value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {W{1'b0}};
        end else if (en && (count_r != {W{1'b1}})) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage with a main entry plus one skid entry and flush.
// Optional stall-cycle counter port enabled by defining PIPE_STALL_CNT_EN.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W_DEF,
    parameter int DATA_W = PIPE_DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    pipe_state_e       state_r;
    pipe_state_e       state_nxt_s;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [CTRL_W-1:0] main_ctrl_r;
    logic [DATA_W-1:0] main_data_r;
    logic [CTRL_W-1:0] skid_ctrl_r;
    logic [DATA_W-1:0] skid_data_r;

    logic in_xfer_s;
    logic out_xfer_s;
    logic load_main_in_s;
    logic load_main_skid_s;
    logic load_skid_s;
    logic clear_main_s;

    assign in_xfer_s  = in_valid & in_ready_r;
    assign out_xfer_s = out_valid_r & out_ready;

    // Next occupancy and which storage moves this cycle; flush overrides all.
    always_comb begin
        state_nxt_s      = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        clear_main_s     = 1'b0;
        if (flush) begin
            state_nxt_s  = EMPTY;
            clear_main_s = 1'b1;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_xfer_s) begin
                        state_nxt_s    = ONE;
                        load_main_in_s = 1'b1;
                    end else begin
                        state_nxt_s = EMPTY;
                    end
                end
                ONE: begin
                    if (in_xfer_s && out_xfer_s) begin
                        state_nxt_s    = ONE;
                        load_main_in_s = 1'b1;
                    end else if (in_xfer_s) begin
                        state_nxt_s = FULL;
                        load_skid_s = 1'b1;
                    end else if (out_xfer_s) begin
                        state_nxt_s  = EMPTY;
                        clear_main_s = 1'b1;
                    end else begin
                        state_nxt_s = ONE;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (out_xfer_s) begin
                        state_nxt_s      = ONE;
                        load_main_skid_s = 1'b1;
                    end else begin
                        state_nxt_s = FULL;
                    end
                end
                default: begin
                    state_nxt_s  = EMPTY;
                    clear_main_s = 1'b1;
                end
            endcase
        end
    end

    // Occupancy state plus handshake flags derived from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            out_valid_r <= (state_nxt_s != EMPTY);
            in_ready_r  <= (state_nxt_s != FULL);
        end
    end

    // Main entry; control is zeroed whenever the stage empties so bubbles stay inert.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_ctrl_r <= {CTRL_W{1'b0}};
            main_data_r <= {DATA_W{1'b0}};
        end else if (load_main_in_s) begin
            main_ctrl_r <= in_ctrl;
            main_data_r <= in_data;
        end else if (load_main_skid_s) begin
            main_ctrl_r <= skid_ctrl_r;
            main_data_r <= skid_data_r;
        end else if (clear_main_s) begin
            main_ctrl_r <= {CTRL_W{1'b0}};
            main_data_r <= main_data_r;
        end else begin
            main_ctrl_r <= main_ctrl_r;
            main_data_r <= main_data_r;
        end
    end

    // Skid entry absorbs the one transfer accepted while the consumer stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_ctrl_r <= {CTRL_W{1'b0}};
            skid_data_r <= {DATA_W{1'b0}};
        end else if (load_skid_s) begin
            skid_ctrl_r <= in_ctrl;
            skid_data_r <= in_data;
        end else if (load_main_skid_s || flush) begin
            skid_ctrl_r <= {CTRL_W{1'b0}};
            skid_data_r <= skid_data_r;
        end else begin
            skid_ctrl_r <= skid_ctrl_r;
            skid_data_r <= skid_data_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_ctrl  = main_ctrl_r;
    assign out_data  = main_data_r;

`ifdef PIPE_STALL_CNT_EN
    logic stall_en_s;

    assign stall_en_s = out_valid_r & ~out_ready;

    pipe_sat_counter #(
        .W(STALL_CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (stall_en_s),
        .count (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Randomised bench for pipe_stage_buf against a two-deep FIFO reference model.
// Define PIPE_STALL_CNT_EN to also exercise the stall counter.
module tb_pipe_stage_buf;

    localparam int CW = 3;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
`ifdef PIPE_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t        mq[$];
    int unsigned exp_stall;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic m_valid();
        return mq.size() > 0;
    endfunction

    function automatic logic m_ready();
        return mq.size() < 2;
    endfunction

    function automatic logic [CW-1:0] m_ctrl();
        return (mq.size() > 0) ? mq[0].c : 3'b000;
    endfunction

    function automatic logic [DW-1:0] m_data();
        return (mq.size() > 0) ? mq[0].d : 16'h0000;
    endfunction

    // Drive one cycle of inputs and advance the model past the rising edge.
    task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input logic ordy, input logic fl);
        logic in_x, out_x, ov;
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        ov    = m_valid();
        in_x  = v && m_ready();
        out_x = ov && ordy;
        @(posedge clk);
        if (ov && !ordy && exp_stall < 32'd65535) exp_stall++;
        if (out_x) void'(mq.pop_front());
        if (in_x) mq.push_back({c, d});
        if (fl) mq.delete();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = 3'b000;
        in_data = 16'h0000; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if ({out_valid, in_ready} !== 2'b01) begin n_err++;
            $display("FAIL reset_flags: got %b required 01", {out_valid, in_ready}); end
        n_vec++; if (out_ctrl !== 3'b000 || out_data !== 16'h0000) begin n_err++;
            $display("FAIL reset_bundle: got %b/%h required 000/0000", out_ctrl, out_data); end
        reset = 1'b1; mq.delete(); exp_stall = 0;
        step(1'b1, 3'b011, 16'h1111, 1'b1, 1'b0);
        step(1'b1, 3'b011, 16'h2222, 1'b0, 1'b0);
        step(1'b1, 3'b011, 16'h3333, 1'b0, 1'b0);
        n_vec++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_err++;
            $display("FAIL reset_prefill: got ready=%b valid=%b required 0/1", in_ready, out_valid); end
        #2 reset = 1'b0;
        #1;
        n_vec++; if ({out_valid, in_ready, out_ctrl} !== 5'b01000 || out_data !== 16'h0000) begin n_err++;
            $display("FAIL reset_midstream: got v=%b r=%b c=%b d=%h required 0/1/000/0000",
                     out_valid, in_ready, out_ctrl, out_data); end
`ifdef PIPE_STALL_CNT_EN
        n_vec++; if (stall_cnt !== 16'h0000) begin n_err++;
            $display("FAIL reset_stall_cnt: got %h required 0000", stall_cnt); end
`endif
        @(posedge clk); #1;
        reset = 1'b1; mq.delete(); exp_stall = 0;
    endtask

    task automatic test_streaming();
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 3'b101, 16'(k), 1'b1, 1'b0);
            n_vec++; if (out_valid !== 1'b1 || out_data !== 16'(k) || out_ctrl !== 3'b101 || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL stream_%0d: got v=%b d=%h c=%b r=%b required 1/%h/101/1",
                         k, out_valid, out_data, out_ctrl, in_ready, 16'(k)); end
        end
        step(1'b0, 3'b000, 16'h0000, 1'b1, 1'b0);
        n_vec++; if (out_valid !== 1'b0 || out_ctrl !== 3'b000) begin n_err++;
            $display("FAIL stream_drain: got v=%b c=%b required 0/000", out_valid, out_ctrl); end
    endtask

    task automatic test_back_pressure();
        logic [DW-1:0] got[$];
        int n = 0;
        int acc = 0;
        step(1'b1, 3'b100, 16'hA000, 1'b1, 1'b0);
        n++;
        for (int s = 0; s < 3; s++) begin
            if (in_ready === 1'b1) acc++;
            step(1'b1, 3'b100, 16'hA000 + 16'(n), 1'b0, 1'b0);
            n = mq.size();
            if (s == 0) begin
                n_vec++; if (in_ready !== 1'b0) begin n_err++;
                    $display("FAIL bp_ready_drop: got %b required 0", in_ready); end
            end
        end
        n_vec++; if (acc != 1) begin n_err++;
            $display("FAIL bp_extra_accept: got %0d required 1", acc); end
        for (int s = 0; s < 6; s++) begin
            if (out_valid === 1'b1) got.push_back(out_data);
            step(1'b0, 3'b000, 16'h0000, 1'b1, 1'b0);
        end
        n_vec++; if (got.size() != 2) begin n_err++;
            $display("FAIL bp_delivered_count: got %0d required 2", got.size()); end
        for (int i = 0; i < got.size() && i < 2; i++) begin
            n_vec++; if (got[i] !== 16'hA000 + 16'(i)) begin n_err++;
                $display("FAIL bp_order_%0d: got %h required %h", i, got[i], 16'hA000 + 16'(i)); end
        end
    endtask

    task automatic test_flush();
        step(1'b1, 3'b111, 16'hB001, 1'b0, 1'b0);
        step(1'b1, 3'b111, 16'hB002, 1'b0, 1'b0);
        n_vec++; if (out_ctrl !== 3'b111 || in_ready !== 1'b0) begin n_err++;
            $display("FAIL flush_prefill: got c=%b r=%b required 111/0", out_ctrl, in_ready); end
        step(1'b1, 3'b111, 16'hDEAD, 1'b0, 1'b1);
        n_vec++; if ({out_valid, in_ready, out_ctrl} !== 5'b01000) begin n_err++;
            $display("FAIL flush_full: got v=%b r=%b c=%b required 0/1/000", out_valid, in_ready, out_ctrl); end
        for (int s = 0; s < 3; s++) begin
            step(1'b0, 3'b111, 16'h0000, 1'b1, 1'b0);
            n_vec++; if (out_valid !== 1'b0 || out_ctrl !== 3'b000) begin n_err++;
                $display("FAIL flush_ghost_%0d: got v=%b c=%b required 0/000", s, out_valid, out_ctrl); end
        end
        step(1'b1, 3'b111, 16'hC001, 1'b0, 1'b0);
        step(1'b1, 3'b111, 16'hC002, 1'b1, 1'b1);
        n_vec++; if ({out_valid, in_ready, out_ctrl} !== 5'b01000) begin n_err++;
            $display("FAIL flush_one: got v=%b r=%b c=%b required 0/1/000", out_valid, in_ready, out_ctrl); end
        step(1'b0, 3'b000, 16'h0000, 1'b1, 1'b0);
        n_vec++; if (out_valid !== 1'b0) begin n_err++;
            $display("FAIL flush_one_ghost: got v=%b required 0", out_valid); end
    endtask

    task automatic test_bubble();
        for (int s = 0; s < 4; s++) begin
            step(1'b0, 3'b111, 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            n_vec++; if (out_valid !== 1'b0 || out_ctrl !== 3'b000) begin n_err++;
                $display("FAIL bubble_%0d: got v=%b c=%b required 0/000", s, out_valid, out_ctrl); end
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 400; s++) begin
            step(1'($urandom_range(0, 3) != 0), 3'($urandom), 16'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
            n_vec++; if ({out_valid, in_ready, out_ctrl} !== {m_valid(), m_ready(), m_ctrl()}) begin n_err++;
                $display("FAIL rand_flags_%0d: got v=%b r=%b c=%b required %b/%b/%b",
                         s, out_valid, in_ready, out_ctrl, m_valid(), m_ready(), m_ctrl()); end
            if (m_valid()) begin
                n_vec++; if (out_data !== m_data()) begin n_err++;
                    $display("FAIL rand_data_%0d: got %h required %h", s, out_data, m_data()); end
            end
`ifdef PIPE_STALL_CNT_EN
            n_vec++; if (stall_cnt !== 16'(exp_stall)) begin n_err++;
                $display("FAIL rand_stall_%0d: got %h required %h", s, stall_cnt, 16'(exp_stall)); end
`endif
        end
    endtask

`ifdef PIPE_STALL_CNT_EN
    task automatic test_stall_saturate();
        step(1'b1, 3'b001, 16'h0005, 1'b0, 1'b0);
        for (int s = 0; s < 70000; s++) step(1'b0, 3'b000, 16'h0000, 1'b0, 1'b0);
        n_vec++; if (stall_cnt !== 16'hFFFF) begin n_err++;
            $display("FAIL stall_saturate: got %h required ffff", stall_cnt); end
        step(1'b0, 3'b000, 16'h0000, 1'b0, 1'b1);
        n_vec++; if (stall_cnt !== 16'hFFFF || out_valid !== 1'b0) begin n_err++;
            $display("FAIL stall_after_flush: got %h v=%b required ffff/0", stall_cnt, out_valid); end
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_bubble();
        test_random();
`ifdef PIPE_STALL_CNT_EN
        test_stall_saturate();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
